// File: rtl/dmem_debug_port_if.sv
// rtl/dmem_debug_port_if.sv - host command/response channel bundle for the dmem debug port
interface dmem_debug_port_if #(
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [31:0]      cmd_addr;
    logic [31:0]      cmd_wdata;
    logic [3:0]       cmd_be;
    logic [LEN_W-1:0] cmd_len;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_last;

    // Host side: issues commands, consumes responses
    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be, cmd_len, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_last
    );

    // Debug port side: accepts commands, produces responses
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be, cmd_len, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_last
    );
endinterface

// File: rtl/dmem_debug_port.sv
// rtl/dmem_debug_port.sv - debug master for data memory port B with byte-lane writes and bursts
module dmem_debug_port #(
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    dmem_debug_port_if.slave  host,
    output logic              busy,
    output logic [31:0]       A2,
    output logic [31:0]       WD2,
    output logic [3:0]        WE2,
    input  logic [31:0]       RD2
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR       = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_CAP   = 3'd3,
        S_RSP      = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [3:0]       be;
    logic [LEN_W-1:0] remain;
    logic             is_wr;
    logic [31:0]      rsp_data_q;
    logic             rsp_last_q;

    logic [1:0]       off;
    logic [4:0]       sh_bits;
    logic [7:0]       be_wide;
    logic [3:0]       lanes;
    logic [31:0]      wdata_sh;
    logic             last_beat;

    // Byte offset is kept for the whole burst; lanes shifted past byte 3 fall off
    always_comb begin
        off       = addr[1:0];
        sh_bits   = {off, 3'b000};
        be_wide   = {4'b0000, be} << off;
        lanes     = be_wide[3:0];
        wdata_sh  = wdata << sh_bits;
        last_beat = (remain == '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (host.cmd_valid) begin
                    state_nxt = host.cmd_write ? S_WR : S_RD_ISSUE;
                end
            end
            S_WR: begin
                if (last_beat) begin
                    state_nxt = S_RSP;
                end
            end
            S_RD_ISSUE: begin
                state_nxt = S_RD_CAP;
            end
            S_RD_CAP: begin
                state_nxt = S_RSP;
            end
            S_RSP: begin
                if (host.rsp_ready) begin
                    state_nxt = (is_wr || last_beat) ? S_IDLE : S_RD_ISSUE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; memory write strobes only ever leave WR
    always_comb begin
        host.cmd_ready = (state == S_IDLE);
        host.rsp_valid = (state == S_RSP);
        host.rsp_data  = rsp_data_q;
        host.rsp_last  = rsp_last_q;
        busy           = (state != S_IDLE);
        A2             = addr;
        WE2            = 4'b0000;
        WD2            = 32'h0000_0000;
        if (state == S_WR) begin
            WE2 = lanes;
            WD2 = wdata_sh;
        end
    end

    // Command latch, beat address/count stepping and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= 32'h0000_0000;
            wdata      <= 32'h0000_0000;
            be         <= 4'b0000;
            remain     <= '0;
            is_wr      <= 1'b0;
            rsp_data_q <= 32'h0000_0000;
            rsp_last_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (host.cmd_valid) begin
                        addr   <= host.cmd_addr;
                        wdata  <= host.cmd_wdata;
                        be     <= host.cmd_be;
                        remain <= host.cmd_len;
                        is_wr  <= host.cmd_write;
                    end
                end
                S_WR: begin
                    if (last_beat) begin
                        rsp_data_q <= 32'h0000_0000;
                        rsp_last_q <= 1'b1;
                    end else begin
                        addr   <= addr + 32'd4;
                        remain <= remain - LEN_W'(1);
                    end
                end
                S_RD_CAP: begin
                    rsp_data_q <= RD2 >> sh_bits;
                    rsp_last_q <= last_beat;
                end
                S_RSP: begin
                    if (host.rsp_ready && !is_wr && !last_beat) begin
                        addr   <= addr + 32'd4;
                        remain <= remain - LEN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_debug_port.sv
// tb/tb_dmem_debug_port.sv - randomized self-checking bench for dmem_debug_port
module tb_dmem_debug_port;

    logic        clk;
    logic        rst;
    logic        busy;
    logic [31:0] A2;
    logic [31:0] WD2;
    logic [3:0]  WE2;
    logic [31:0] RD2;

    dmem_debug_port_if #(.LEN_W(8)) host_if ();

    dmem_debug_port #(.LEN_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .host (host_if),
        .busy (busy),
        .A2   (A2),
        .WD2  (WD2),
        .WE2  (WE2),
        .RD2  (RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port-B RAM: byte-lane writes, registered read, 4 KB window
    logic [31:0] ram [0:1023];
    logic        ram_clr;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (WE2[k]) ram[A2[11:2]][8*k +: 8] <= WD2[8*k +: 8];
        end
        RD2 <= ram[A2[11:2]];
    end

    // Reference memory image as the host expects it to be
    logic [31:0] model_mem [0:1024-1];

    int n_checks;
    int n_fails;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_lanes(input logic [3:0] be_in, input int off);
        logic [3:0] r;
        r = 4'b0;
        for (int k = 0; k < 4; k++)
            if (be_in[k] && (k + off) < 4) r[k + off] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [31:0] d, input int off);
        logic [31:0] r;
        r = 32'h0;
        for (int j = 0; j < 4; j++)
            if (j >= off) r[8*j +: 8] = d[8*(j-off) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] word, input int off);
        logic [31:0] r;
        r = 32'h0;
        for (int j = 0; j < 4; j++)
            if (j + off < 4) r[8*j +: 8] = word[8*(j+off) +: 8];
        return r;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be_in);
        int off;
        logic [3:0]  ln;
        logic [31:0] wd;
        off = int'(a[1:0]);
        ln  = exp_lanes(be_in, off);
        wd  = exp_wd(d, off);
        for (int k = 0; k < 4; k++)
            if (ln[k]) model_mem[a[11:2]][8*k +: 8] = wd[8*k +: 8];
    endtask

    task automatic take_rsp(input logic [31:0] ed, input logic el, input int stall);
        check("rsp_valid", 32'(host_if.rsp_valid), 32'd1);
        check("rsp_data", host_if.rsp_data, ed);
        check("rsp_last", 32'(host_if.rsp_last), 32'(el));
        for (int s = 0; s < stall; s++) begin
            host_if.rsp_ready = 1'b0;
            @(posedge clk); @(negedge clk);
            check("stall_valid", 32'(host_if.rsp_valid), 32'd1);
            check("stall_data", host_if.rsp_data, ed);
            check("stall_last", 32'(host_if.rsp_last), 32'(el));
        end
        host_if.rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        host_if.rsp_ready = 1'b0;
    endtask

    task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be_in, input int len, input int stall_beat,
                           input int stall_n);
        logic [31:0] a;
        int off;
        off = int'(addr[1:0]);
        @(negedge clk);
        host_if.cmd_valid = 1'b1;
        host_if.cmd_write = wr;
        host_if.cmd_addr  = addr;
        host_if.cmd_wdata = wdata;
        host_if.cmd_be    = be_in;
        host_if.cmd_len   = 8'(len);
        check("cmd_ready_idle", 32'(host_if.cmd_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        host_if.cmd_valid = 1'b0;
        host_if.cmd_addr  = $urandom;
        if (wr) begin
            for (int b = 0; b <= len; b++) begin
                a = addr + 32'(4 * b);
                check("wr_we2", 32'(WE2), 32'(exp_lanes(be_in, off)));
                check("wr_a2", A2, a);
                check("wr_wd2", WD2, exp_wd(wdata, off));
                check("wr_rsp_valid", 32'(host_if.rsp_valid), 32'd0);
                check("wr_busy", 32'(busy), 32'd1);
                model_write(a, wdata, be_in);
                @(posedge clk); @(negedge clk);
            end
            check("ack_we2", 32'(WE2), 32'd0);
            take_rsp(32'h0, 1'b1, stall_n);
        end else begin
            for (int b = 0; b <= len; b++) begin
                a = addr + 32'(4 * b);
                check("rd_a2", A2, a);
                check("rd_we2", 32'(WE2), 32'd0);
                check("rd_wd2", WD2, 32'd0);
                check("rd_issue_valid", 32'(host_if.rsp_valid), 32'd0);
                @(posedge clk); @(negedge clk);
                check("rd_cap_valid", 32'(host_if.rsp_valid), 32'd0);
                @(posedge clk); @(negedge clk);
                take_rsp(exp_rd(model_mem[a[11:2]], off), (b == len),
                         (b == stall_beat) ? stall_n : 0);
            end
        end
        check("cmd_ready_after", 32'(host_if.cmd_ready), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        n_checks = 0;
        n_fails  = 0;
        for (int i = 0; i < 1024; i++) model_mem[i] = 32'h0;
        rst = 1'b1;
        ram_clr = 1'b1;
        host_if.cmd_valid = 1'b0;
        host_if.cmd_write = 1'b0;
        host_if.cmd_addr  = 32'h0;
        host_if.cmd_wdata = 32'h0;
        host_if.cmd_be    = 4'h0;
        host_if.cmd_len   = 8'h0;
        host_if.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(host_if.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(host_if.rsp_valid), 32'd0);
        check("rst_rsp_data", host_if.rsp_data, 32'd0);
        check("rst_rsp_last", 32'(host_if.rsp_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_a2", A2, 32'd0);
        check("rst_wd2", WD2, 32'd0);
        check("rst_we2", 32'(WE2), 32'd0);
        rst = 1'b0;
        ram_clr = 1'b0;

        // Unaligned byte write and shifted readback
        run_cmd(1'b1, 32'h103, 32'h0000_00AB, 4'h1, 0, -1, 0);
        run_cmd(1'b0, 32'h100, 32'h0, 4'h0, 0, -1, 0);
        check("unaligned_word", model_mem[32'h100 >> 2], 32'hAB00_0000);
        run_cmd(1'b0, 32'h102, 32'h0, 4'h0, 0, -1, 0);

        // Aligned write and read
        run_cmd(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 0, -1, 1);
        run_cmd(1'b0, 32'h100, 32'h0, 4'h0, 0, -1, 0);

        // Fill burst, then read burst with a 5-cycle stall on beat 1
        run_cmd(1'b1, 32'h200, 32'h5A5A_5A5A, 4'hF, 3, -1, 0);
        run_cmd(1'b0, 32'h200, 32'h0, 4'h0, 3, 1, 5);

        // Empty byte enable still acks; high lanes dropped on offset 3
        run_cmd(1'b1, 32'h240, 32'h1234_5678, 4'h0, 1, -1, 0);
        run_cmd(1'b1, 32'h247, 32'hCAFE_F00D, 4'hF, 0, -1, 0);
        run_cmd(1'b0, 32'h244, 32'h0, 4'h0, 0, -1, 0);

        // Address wrap-around
        run_cmd(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 1, -1, 0);

        // Reset during the 3rd write beat: three beats land, nothing after
        @(negedge clk);
        host_if.cmd_valid = 1'b1;
        host_if.cmd_write = 1'b1;
        host_if.cmd_addr  = 32'h300;
        host_if.cmd_wdata = 32'h1122_3344;
        host_if.cmd_be    = 4'hF;
        host_if.cmd_len   = 8'd7;
        @(posedge clk); @(negedge clk);
        host_if.cmd_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            check("rstb_we2", 32'(WE2), 32'hF);
            model_write(32'h300 + 32'(4 * b), 32'h1122_3344, 4'hF);
            if (b < 2) begin
                @(posedge clk); @(negedge clk);
            end
        end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rstb_we2_off", 32'(WE2), 32'd0);
        check("rstb_rsp_valid", 32'(host_if.rsp_valid), 32'd0);
        rst = 1'b0;
        host_if.rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); @(negedge clk);
            check("rstb_cmd_ready", 32'(host_if.cmd_ready), 32'd1);
            check("rstb_idle_we2", 32'(WE2), 32'd0);
            check("rstb_no_ack", 32'(host_if.rsp_valid), 32'd0);
        end
        host_if.rsp_ready = 1'b0;
        run_cmd(1'b0, 32'h300, 32'h0, 4'h0, 7, -1, 0);

        // Randomized commands against the reference image
        for (int n = 0; n < 40; n++) begin
            ra = ($urandom & 32'h0000_0FFC) | 32'($urandom_range(0, 3));
            run_cmd(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/dmem_debug_port.md
# dmem_debug_port

Debug-side master for port B of the data memory inside the MEM/WB segment register. It accepts read and write commands from a host link over a valid/ready interface and drives the memory's A2/WD2/WE2 port. It captures the synchronous RD2 read data and returns it over a valid/ready response channel. It supports byte-lane writes, fill bursts and read bursts, so the host can inspect and initialise data memory while the CPU runs on port A.

## Interface
Parameters:
- LEN_W, 8, width of burst length field; a burst is cmd_len+1 beats.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  host command present
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address of first beat
- cmd_wdata  in  32  write data, low-aligned; repeated on every write beat (fill)
- cmd_be  in  4  byte enables, low-aligned
- cmd_len  in  LEN_W  beats minus one
- rsp_valid  out  1  response present
- rsp_ready  in  1  host accepts response
- rsp_data  out  32  read data, low-aligned; 0 for write acks
- rsp_last  out  1  final response of the command
- busy  out  1  command in progress (state != IDLE)
- A2  out  32  memory port-B byte address; the memory uses A2[31:2]
- WD2  out  32  memory port-B write data
- WE2  out  4  memory port-B byte write enables
- RD2  in  32  memory port-B read data, valid one cycle after A2 is presented

## Operation
Latched command registers: addr, wdata, be, remain (LEN_W bits), is_wr. The byte offset is off = addr[1:0].

FSM states and transitions:
- IDLE
  - cmd_ready = 1.
  - On cmd_valid, latch the command. Go to WR if cmd_write, else to RD_ISSUE.
- WR
  - A2 = addr, WE2 = (be << off)[3:0], WD2 = wdata << (8*off).
  - If remain == 0, go to RSP.
  - Else addr += 4, remain -= 1, and stay in WR.
- RD_ISSUE
  - A2 = addr, WE2 = 0.
  - Go to RD_CAP.
- RD_CAP
  - rsp_data <= RD2 >> (8*off), zero-filled.
  - rsp_last <= (remain == 0).
  - Go to RSP.
- RSP
  - rsp_valid = 1, held stable until rsp_ready.
  - On rsp_ready: if is_wr or remain == 0, go to IDLE.
  - Otherwise addr += 4, remain -= 1, and go to RD_ISSUE.

Output rules:
- A write command produces exactly one response: rsp_data = 0, rsp_last = 1.
- A read command produces cmd_len+1 responses; only the last one has rsp_last = 1.
- WE2 is nonzero only in WR. In every other state WE2 = 0, A2 holds addr and WD2 = 0.
- Byte enables shifted past bit 3 are dropped. The block does not split unaligned accesses across words.
- The address increments by 4 with modulo-2^32 wrap-around, so 0xFFFFFFFC + 4 = 0x00000000. The offset is preserved across beats.
- cmd_be = 0 performs a write with no lanes enabled. It still takes the cycles and still returns an ack.
- cmd_valid is ignored outside IDLE, because cmd_ready = 0 there.

Reset:
- Reset values: state = IDLE, cmd_ready = 1, rsp_valid = 0, rsp_data = 0, rsp_last = 0, busy = 0, A2 = 0, WD2 = 0, WE2 = 0, and all latched registers 0.
- Reset in any state aborts the command immediately. No further memory write occurs after the reset edge, and any pending response is discarded.

## Timing
Cycle 0 is the clock edge at which cmd_valid && cmd_ready is sampled.
- Single write: WE2 is active during cycle 1. rsp_valid rises in cycle 2.
- N-beat write: WE2 is active during cycles 1..N. rsp_valid rises in cycle N+1.
- Single read: A2 is presented in cycle 1, RD2 is sampled at the end of cycle 2, and rsp_valid is asserted in cycle 3.
- Read burst: each later beat starts its RD_ISSUE in the cycle after the rsp_ready handshake. With rsp_ready held high the throughput is one beat per 3 cycles.
- Back-to-back commands: the earliest next cmd_ready is the cycle after the final response handshake.
- rsp_data and rsp_last are registered and stable while rsp_valid = 1 && rsp_ready = 0.
- A port-A write and a port-B read of the same word in the same cycle return the old data on RD2. The memory handles this; the block does not check for it.

## Test plan
- Single aligned write then read:
  - Write addr 0x100, wdata 0xDEADBEEF, be 0xF: WE2 = 0xF for exactly 1 cycle with A2 = 0x100, then an ack with rsp_last = 1.
  - Read 0x100: rsp_data = 0xDEADBEEF in cycle 3.
- Unaligned byte write:
  - Write addr 0x103, wdata 0x000000AB, be 0x1: WE2 = 0x8, WD2 = 0xAB000000.
  - A read of 0x100 with prior contents 0 returns 0xAB000000. A read of 0x102 returns 0x0000AB00.
- Fill burst: write addr 0x200, len 3, wdata 0x5A5A5A5A. Four consecutive WE2 = 0xF cycles at 0x200, 0x204, 0x208 and 0x20C, then exactly one ack.
- Read burst with backpressure: read addr 0x200, len 3, with rsp_ready low for 5 cycles on beat 1. Four responses of 0x5A5A5A5A arrive, rsp_last is set only on the 4th, and rsp_data stays stable while stalled.
- Wrap-around: read addr 0xFFFFFFFC, len 1. A2 sequence is 0xFFFFFFFC then 0x00000000.
- Reset mid-burst: write len 7, with rst asserted during the 3rd WR cycle. WE2 = 0 from the next cycle onward, no ack is produced, and cmd_ready = 1 the cycle after rst deasserts.
